execute_stage: RTL and testbench

Consumer side of the D→E pipeline register in the Y86-64 pipelined core. Reads the latched E_* fields and produces the execute-stage signals:
- ALU result, condition evaluation and forwarding outputs, all combinational.
- The architectural condition-code register, sequential.
- The E→M pipeline register (M_*), with stall/bubble control.

The block sits between the execute pipeline register and the memory stage.

---
 rtl/y86_pkg.sv | 68 ++++++
 rtl/y86_alu.sv | 43 ++++
 rtl/execute_stage.sv | 135 +++++++++++++
 tb/tb_execute_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, ALU functions, condition codes, status.
// Used by every pipeline-stage module of the core.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_t;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] R_NONE = 4'hF;

  localparam logic [2:0] BUB_STAT  = S_AOK;
  localparam logic [3:0] BUB_ICODE = I_NOP;

  function automatic logic stat_ok(input logic [2:0] s);
    return !(s == S_ADR || s == S_INS || s == S_HLT);
  endfunction

  function automatic logic cond_eval(
    input logic [3:0] ifun,
    input logic       zf,
    input logic       sf,
    input logic       of
  );
    logic lt;
    lt = sf ^ of;
    case (ifun)
      C_ALWAYS: return 1'b1;
      C_LE:     return lt | zf;
      C_L:      return lt;
      C_E:      return zf;
      C_NE:     return ~zf;
      C_GE:     return ~lt;
      C_G:      return ~lt & ~zf;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: result = b op a, with ZF/SF/OF.
// Wraps modulo 2^W; AND/XOR never overflow.
module y86_alu
  import y86_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] alu_a,
  input  logic [W-1:0] alu_b,
  input  alu_fun_t     alu_fun,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  logic sa, sb, sr;

  assign sa = alu_a[W-1];
  assign sb = alu_b[W-1];
  assign sr = result[W-1];

  always_comb begin
    result = '0;
    of     = 1'b0;
    unique case (alu_fun)
      ALU_ADD: begin
        result = alu_b + alu_a;
        of     = (sa == sb) && (sr != sa);
      end
      ALU_SUB: begin
        result = alu_b - alu_a;
        of     = (sb != sa) && (sr != sb);
      end
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
    endcase
  end

  assign zf = (result == '0);
  assign sf = sr;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, CC register, cmov squash, E->M register.
// Define EXEC_IADDQ_EN to add the IADDQ (icode C) instruction.
module execute_stage
  import y86_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter logic [3:0]  RNONE = R_NONE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valC,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [2:0]   m_stat,
  input  logic [2:0]   W_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic [W-1:0] e_valE,
  output logic         e_Cnd,
  output logic [3:0]   e_dstE,
  output logic [2:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  localparam logic [W-1:0] STEP = W'(8);

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  alu_fun_t     alu_fun;
  logic         alu_zf;
  logic         alu_sf;
  logic         alu_of;
  logic         is_alu_op;
  logic         set_cc;

  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:             alu_a = '0 - STEP;
      I_RET, I_POPQ:               alu_a = STEP;
`ifdef EXEC_IADDQ_EN
      I_IADDQ:                     alu_a = E_valC;
`endif
      default:                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ,
      I_CALL, I_PUSHQ,
      I_RET, I_POPQ:               alu_b = E_valB;
`ifdef EXEC_IADDQ_EN
      I_IADDQ:                     alu_b = E_valB;
`endif
      default:                     alu_b = '0;
    endcase
  end

  assign alu_fun = (E_icode == I_OPQ)
                 ? alu_fun_t'(E_ifun[1:0])
                 : ALU_ADD;

  y86_alu #(.W(W)) u_alu (
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .result  (e_valE),
    .zf      (alu_zf),
    .sf      (alu_sf),
    .of      (alu_of)
  );

  always_comb begin
    is_alu_op = (E_icode == I_OPQ);
`ifdef EXEC_IADDQ_EN
    if (E_icode == I_IADDQ) is_alu_op = 1'b1;
`endif
  end

  // Excepting instructions further down must not leave CC side effects.
  assign set_cc = is_alu_op && stat_ok(m_stat) && stat_ok(W_stat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= alu_zf;
      cc_sf <= alu_sf;
      cc_of <= alu_of;
    end
  end

  assign e_Cnd  = cond_eval(E_ifun, cc_zf, cc_sf, cc_of);
  assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk) begin
    if (!rst_n || M_bubble) begin
      M_stat  <= BUB_STAT;
      M_icode <= BUB_ICODE;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a behavioural reference model.
// Honours EXEC_IADDQ_EN the same way the design does.
module tb_execute_stage;

`ifdef EXEC_IADDQ_EN
  localparam bit IADDQ = 1'b1;
`else
  localparam bit IADDQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM;
  logic [2:0]  m_stat, W_stat;
  logic        M_stall, M_bubble;
  logic [63:0] e_valE;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic        cc_zf, cc_sf, cc_of;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // ---- reference model ----
  // {valE, zf, sf, of} of an arithmetic instruction, via 65-bit signed math
  function automatic logic [66:0] f_alu(input logic [3:0] ic, fn,
                                        input logic [63:0] c, a, b);
    logic signed [64:0] x, y, s;
    logic [63:0] r;
    logic o;
    y = {b[63], b};
    x = (ic == 4'hC) ? {c[63], c} : {a[63], a};
    o = 1'b0;
    s = '0;
    if (ic == 4'hC || fn == 4'd0) s = y + x;
    else if (fn == 4'd1) s = y - x;
    r = s[63:0];
    if (ic == 4'h6 && fn == 4'd2) r = a & b;
    if (ic == 4'h6 && fn == 4'd3) r = a ^ b;
    if (ic == 4'hC || fn <= 4'd1) o = (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) ||
                                      (s < -65'sh0_8000_0000_0000_0000);
    return {r, r == 64'd0, r[63], o};
  endfunction

  function automatic logic [63:0] f_valE(input logic [3:0] ic, fn,
                                         input logic [63:0] c, a, b);
    logic [66:0] t;
    t = f_alu(ic, fn, c, a, b);
    case (ic)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h6: return t[66:3];
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      4'hC: return IADDQ ? t[66:3] : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic f_cnd(input logic [3:0] fn,
                                 input logic z, s, o);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (s != o) || z;
      4'd2: return s != o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return s == o;
      4'd6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic f_setcc(input logic [3:0] ic,
                                   input logic [2:0] ms, ws);
    logic bad;
    bad = (ms inside {3'd2, 3'd3, 3'd4}) || (ws inside {3'd2, 3'd3, 3'd4});
    return (ic == 4'h6 || (IADDQ && ic == 4'hC)) && !bad;
  endfunction

  bit          mvalid = 1'b0;
  logic        mzf, msf, mof;
  logic [2:0]  ms;
  logic [3:0]  mi, mde, mdm;
  logic        mc;
  logic [63:0] mve, mva;

  function automatic logic [3:0] f_dst(input logic [3:0] ic, d,
                                       input logic cnd);
    return (ic == 4'h2 && !cnd) ? 4'hF : d;
  endfunction

  always @(posedge clk) begin
    logic [66:0] t;
    logic cnd;
    t   = f_alu(E_icode, E_ifun, E_valC, E_valA, E_valB);
    cnd = f_cnd(E_ifun, mzf, msf, mof);
    if (!rst_n) begin
      {mzf, msf, mof} <= 3'b100;
      mvalid <= 1'b1;
    end else if (f_setcc(E_icode, m_stat, W_stat)) begin
      {mzf, msf, mof} <= t[2:0];
    end
    if (!rst_n || M_bubble) begin
      ms <= 3'd1; mi <= 4'h1; mc <= 1'b0;
      mve <= '0; mva <= '0; mde <= 4'hF; mdm <= 4'hF;
    end else if (!M_stall) begin
      ms  <= E_stat;
      mi  <= E_icode;
      mc  <= cnd;
      mve <= f_valE(E_icode, E_ifun, E_valC, E_valA, E_valB);
      mva <= E_valA;
      mde <= f_dst(E_icode, E_dstE, cnd);
      mdm <= E_dstM;
    end
  end

  always @(negedge clk) begin
    logic cnd;
    if (mvalid) begin
      cnd = f_cnd(E_ifun, mzf, msf, mof);
      chk("e_valE", 128'(e_valE),
          128'(f_valE(E_icode, E_ifun, E_valC, E_valA, E_valB)));
      chk("e_Cnd", 128'(e_Cnd), 128'(cnd));
      chk("e_dstE", 128'(e_dstE), 128'(f_dst(E_icode, E_dstE, cnd)));
      chk("M_ctl", 128'({M_stat, M_icode, M_Cnd, M_dstE, M_dstM}),
          128'({ms, mi, mc, mde, mdm}));
      chk("M_valE", 128'(M_valE), 128'(mve));
      chk("M_valA", 128'(M_valA), 128'(mva));
      chk("cc", 128'({cc_zf, cc_sf, cc_of}), 128'({mzf, msf, mof}));
    end
  end

  // ---- stimulus ----
  task automatic drive(input logic [3:0] ic, fn,
                       input logic [63:0] c, a, b,
                       input logic [3:0] de);
    E_icode = ic; E_ifun = fn;
    E_valC = c; E_valA = a; E_valB = b;
    E_dstE = de; E_dstM = 4'hF;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; E_stat = 3'd1; m_stat = 3'd1; W_stat = 3'd1;
    M_stall = 1'b0; M_bubble = 1'b0;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    tick;
    chk("rst_cc", 128'({cc_zf, cc_sf, cc_of}), 128'(3'b100));
    chk("rst_icode", 128'(M_icode), 128'(4'h1));
    chk("rst_dst", 128'({M_dstE, M_dstM}), 128'(8'hFF));
    chk("rst_valE", 128'(M_valE), 128'(0));
    rst_n = 1'b1;

    drive(4'h6, 4'h1, 64'd0, 64'd7, 64'd5, 4'h3);
    #1 chk("sub_valE", 128'(e_valE), 128'(64'hFFFF_FFFF_FFFF_FFFE));
    tick;
    chk("sub_cc", 128'({cc_zf, cc_sf, cc_of}), 128'(3'b010));
    drive(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF,
          64'h7FFF_FFFF_FFFF_FFFF, 4'h3);
    tick;
    chk("add_ovf_cc", 128'({cc_zf, cc_sf, cc_of}), 128'(3'b011));

    drive(4'h6, 4'h3, 64'd0, 64'd5, 64'd5, 4'h3);
    tick;
    drive(4'h2, 4'h1, 64'd0, 64'h55, 64'd0, 4'h3);
    #1 chk("cmovle_take", 128'({e_Cnd, e_dstE}), 128'(5'h13));
    tick;
    drive(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h1);
    tick;
    drive(4'h2, 4'h1, 64'd0, 64'h55, 64'd0, 4'h3);
    #1 chk("cmovle_skip", 128'({e_Cnd, e_dstE}), 128'(5'h0F));
    tick;
    chk("cmovle_M_dstE", 128'(M_dstE), 128'(4'hF));

    drive(4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h1);
    m_stat = 3'd3;
    tick;
    chk("gate_m_adr", 128'(cc_zf), 128'(0));
    m_stat = 3'd1; W_stat = 3'd4;
    tick;
    chk("gate_w_ins", 128'(cc_zf), 128'(0));
    W_stat = 3'd1;
    tick;
    chk("gate_open", 128'(cc_zf), 128'(1));

    drive(4'hA, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4);
    #1 chk("pushq", 128'(e_valE), 128'(64'hF8));
    tick;
    drive(4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4);
    #1 chk("popq", 128'(e_valE), 128'(64'h108));
    tick;
    drive(4'h3, 4'h0, 64'h2A, 64'd0, 64'd0, 4'h2);
    #1 chk("irmovq", 128'(e_valE), 128'(64'h2A));
    tick;

    // remaining icodes, unknown codes and OPQ AND; model does the checking
    for (int i = 0; i < 16; i++) begin
      E_stat = (i == 0) ? 3'd2 : 3'd1;
      drive(4'(i), 4'h2, 64'h30, 64'hF0F0, 64'h0FF0 + 64'(i), 4'h5);
      tick;
    end
    E_stat = 3'd1;
    drive(4'h6, 4'h2, 64'd0, 64'hF0, 64'h0F, 4'h5);
    tick;
    for (int k = 0; k < 3; k++) begin
      for (int f = 0; f < 8; f++) begin
        drive(4'h2, 4'(f), 64'd0, 64'h77, 64'd0, 4'h6);
        tick;
      end
      if (k == 0) drive(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h1);
      else drive(4'h6, 4'h1, 64'd0, 64'h8000_0000_0000_0000, 64'd1, 4'h1);
      tick;
    end

    drive(4'h6, 4'h0, 64'd0, 64'd3, 64'd4, 4'h2);
    tick;
    chk("load_valE", 128'(M_valE), 128'(64'd7));
    M_stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(4'h6, 4'h0, 64'd0, 64'(10 * j), 64'd20, 4'h4);
      tick;
      chk("stall_hold", 128'({M_valE, M_dstE}), 128'({64'd7, 4'h2}));
    end
    M_bubble = 1'b1;
    tick;
    chk("bubble_ctl", 128'({M_icode, M_dstE, M_dstM}), 128'(12'h1FF));
    chk("bubble_valE", 128'(M_valE), 128'(0));
    M_bubble = 1'b0; M_stall = 1'b0;

    drive(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2);
    tick;
    drive(4'h6, 4'h1, 64'd0, 64'd3, 64'd2, 4'h2);
    M_stall = 1'b1; rst_n = 1'b0;
    tick;
    chk("midrst_cc", 128'({cc_zf, cc_sf, cc_of}), 128'(3'b100));
    chk("midrst_icode", 128'(M_icode), 128'(4'h1));
    rst_n = 1'b1; M_stall = 1'b0;
    tick;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
